video_timing: RTL and testbench

VIDEO_TIMING -- requirements
Module: video_timing

---
 rtl/video_timing.sv | 125 ++++++++++++
 tb/tb_video_timing.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing.sv
// video_timing -- raster timing generator.
//
// Walks a signed (hpos, vpos) position through one frame. Blanking sits at
// negative coordinates (front porch, sync, back porch) and the active picture
// starts at (0,0), so pixel logic can test visibility with sign bits alone.
// All status outputs are registered from the same next-position value as
// hpos/vpos, which keeps them aligned with the coordinates they describe.
//
// Optional build macro:
//   VIDEO_TIMING_FRAME_CNT_EN  -- enables the 16-bit frame counter. When it is
//                                 undefined, frame_count is tied to zero.
//
// Ports:
//   pixel_clk    in   pixel clock
//   rst          in   synchronous active-high reset
//   en           in   advance enable; when low, every output holds and fsync is 0
//   hpos         out  signed horizontal position, -H_BLANK .. H_ACTIVE-1
//   vpos         out  signed vertical position, -V_BLANK .. V_ACTIVE-1
//   hsync        out  horizontal sync; SYNC_POL=1 makes it active-high
//   vsync        out  vertical sync; SYNC_POL=1 makes it active-high
//   de           out  data enable, high in the active region
//   fsync        out  one-cycle pulse when the frame's first position appears
//   frame_count  out  frame counter (see the macro above)

module video_timing #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int SYNC_POL = 1
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               en,
    output logic signed [11:0] hpos,
    output logic signed [11:0] vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               fsync,
    output logic [15:0]        frame_count
);

    localparam int H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int V_BLANK = V_FP + V_SYNC + V_BP;

    localparam logic signed [11:0] H_FIRST   = 12'(-H_BLANK);
    localparam logic signed [11:0] H_LAST    = 12'(H_ACTIVE - 1);
    localparam logic signed [11:0] V_FIRST   = 12'(-V_BLANK);
    localparam logic signed [11:0] V_LAST    = 12'(V_ACTIVE - 1);
    localparam logic signed [11:0] HS_FIRST  = 12'(H_FP - H_BLANK);
    localparam logic signed [11:0] HS_LAST   = 12'(-H_BP - 1);
    localparam logic signed [11:0] VS_FIRST  = 12'(V_FP - V_BLANK);
    localparam logic signed [11:0] VS_LAST   = 12'(-V_BP - 1);
    localparam logic               SYNC_ACT  = (SYNC_POL != 0);

    logic signed [11:0] h_nxt;
    logic signed [11:0] v_nxt;
    logic               hs_nxt;
    logic               vs_nxt;
    logic               start_nxt;

    always_comb begin
        h_nxt = hpos + 12'sd1;
        v_nxt = vpos;
        if (hpos == H_LAST) begin
            h_nxt = H_FIRST;
            v_nxt = (vpos == V_LAST) ? V_FIRST : vpos + 12'sd1;
        end
    end

    // Status is computed from the position about to be presented, so it
    // lands in the same register stage as hpos/vpos.
    always_comb begin
        hs_nxt    = (h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST);
        vs_nxt    = (v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST);
        start_nxt = (h_nxt == H_FIRST) && (v_nxt == V_FIRST);
    end

    // Reset parks the counters on the last pixel of the frame, so the first
    // enabled advance wraps to the frame start and raises fsync. Since the
    // start position is only ever reached by advancing, a stall on the fsync
    // cycle cannot produce a second pulse.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hpos  <= H_LAST;
            vpos  <= V_LAST;
            hsync <= ~SYNC_ACT;
            vsync <= ~SYNC_ACT;
            de    <= 1'b0;
            fsync <= 1'b0;
        end else if (en) begin
            hpos  <= h_nxt;
            vpos  <= v_nxt;
            hsync <= hs_nxt ? SYNC_ACT : ~SYNC_ACT;
            vsync <= vs_nxt ? SYNC_ACT : ~SYNC_ACT;
            de    <= ~h_nxt[11] & ~v_nxt[11];
            fsync <= start_nxt;
        end else begin
            fsync <= 1'b0;
        end
    end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    // Counts on the same edge that raises fsync, so the first frame reads 1.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (en && start_nxt) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign frame_count = frame_cnt;
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing -- self-checking bench for video_timing.
//
// Uses a reduced raster so that whole frames fit in a short run. The
// reference model tracks a linear pixel index within the frame and derives
// the coordinates and region flags from it arithmetically. A second instance
// with SYNC_POL=0 covers the inverted sync polarity.

module tb_video_timing;

    localparam int HA  = 16;
    localparam int HF  = 3;
    localparam int HS  = 4;
    localparam int HB  = 5;
    localparam int VA  = 8;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int HBL = HF + HS + HB;
    localparam int VBL = VF + VS + VB;
    localparam int HT  = HA + HBL;
    localparam int VT  = VA + VBL;
    localparam int TOTAL = HT * VT;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic pixel_clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 pixel_clk = ~pixel_clk;

    logic signed [11:0] hpos_a, vpos_a, hpos_b, vpos_b;
    logic hsync_a, vsync_a, de_a, fsync_a;
    logic hsync_b, vsync_b, de_b, fsync_b;
    logic [15:0] frame_count_a, frame_count_b;

    video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1)
    ) dut_a (
        .pixel_clk(pixel_clk), .rst(rst), .en(en),
        .hpos(hpos_a), .vpos(vpos_a), .hsync(hsync_a), .vsync(vsync_a),
        .de(de_a), .fsync(fsync_a), .frame_count(frame_count_a)
    );

    video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
    ) dut_b (
        .pixel_clk(pixel_clk), .rst(rst), .en(en),
        .hpos(hpos_b), .vpos(vpos_b), .hsync(hsync_b), .vsync(vsync_b),
        .de(de_b), .fsync(fsync_b), .frame_count(frame_count_b)
    );

    wire [43:0] vec_a = {hpos_a, vpos_a, hsync_a, vsync_a, de_a, fsync_a, frame_count_a};
    wire [43:0] vec_b = {hpos_b, vpos_b, hsync_b, vsync_b, de_b, fsync_b, frame_count_b};

    // Reference model: t is the pixel index in the frame (0 = frame start),
    // fresh marks the post-reset state where status outputs are all idle.
    int t;
    bit fresh;
    bit fs;
    int fc;
    int tests = 0;
    int fails = 0;

    function automatic logic [43:0] exp_vec(input bit pol);
        int hx;
        int vy;
        logic signed [11:0] h;
        logic signed [11:0] v;
        bit ha;
        bit va;
        bit d;
        hx = t % HT;
        vy = t / HT;
        h  = 12'(hx - HBL);
        v  = 12'(vy - VBL);
        ha = !fresh && (hx >= HF) && (hx < HF + HS);
        va = !fresh && (vy >= VF) && (vy < VF + VS);
        d  = !fresh && (hx >= HBL) && (vy >= VBL);
        return {h, v, pol ? ha : !ha, pol ? va : !va, d, fs, 16'(fc)};
    endfunction

    task automatic step(input bit r, input bit e);
        rst = r;
        en  = e;
        @(posedge pixel_clk);
        if (r) begin
            t = TOTAL - 1;
            fresh = 1'b1;
            fs = 1'b0;
            fc = 0;
        end else if (e) begin
            t = (t + 1) % TOTAL;
            fresh = 1'b0;
            fs = (t == 0);
            if (fs && FC_EN) fc = (fc + 1) % 65536;
        end else begin
            fs = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, (i % 2) == 0);
            tests++;
            if (vec_a !== exp_vec(1'b1)) begin
                fails++;
                $display("FAIL reset_a: got %h expected %h", vec_a, exp_vec(1'b1));
            end
            tests++;
            if (vec_b !== exp_vec(1'b0)) begin
                fails++;
                $display("FAIL reset_b: got %h expected %h", vec_b, exp_vec(1'b0));
            end
        end
        tests++;
        if (hpos_a !== 12'(HA - 1) || vpos_a !== 12'(VA - 1)) begin
            fails++;
            $display("FAIL reset_pos: got %0d,%0d expected %0d,%0d", hpos_a, vpos_a, HA - 1, VA - 1);
        end
    endtask

    task automatic test_first_cycle();
        step(1'b0, 1'b1);
        tests++;
        if (vec_a !== exp_vec(1'b1)) begin
            fails++;
            $display("FAIL first_cycle: got %h expected %h", vec_a, exp_vec(1'b1));
        end
        tests++;
        if (fsync_a !== 1'b1 || hpos_a !== 12'(-HBL) || vpos_a !== 12'(-VBL)) begin
            fails++;
            $display("FAIL first_fsync: got fsync=%b pos=%0d,%0d expected 1 at %0d,%0d",
                     fsync_a, hpos_a, vpos_a, -HBL, -VBL);
        end
    endtask

    task automatic test_full_frame();
        int n_hs = 0;
        int n_vs = 0;
        int n_de = 0;
        int since = 0;
        int bad = 0;
        n_hs += hsync_a;
        n_vs += vsync_a;
        n_de += de_a;
        for (int i = 1; i < TOTAL; i++) begin
            step(1'b0, 1'b1);
            since++;
            n_hs += hsync_a;
            n_vs += vsync_a;
            n_de += de_a;
            if (vec_a !== exp_vec(1'b1) || vec_b !== exp_vec(1'b0)) begin
                bad++;
                if (bad < 5)
                    $display("FAIL frame_walk: got %h/%h expected %h/%h",
                             vec_a, vec_b, exp_vec(1'b1), exp_vec(1'b0));
            end
        end
        tests++;
        if (bad != 0) fails++;
        tests++;
        if (n_hs != HS * VT || n_vs != VS * HT || n_de != HA * VA) begin
            fails++;
            $display("FAIL region_counts: got hs=%0d vs=%0d de=%0d expected %0d %0d %0d",
                     n_hs, n_vs, n_de, HS * VT, VS * HT, HA * VA);
        end
        step(1'b0, 1'b1);
        since++;
        tests++;
        if (fsync_a !== 1'b1 || since != TOTAL) begin
            fails++;
            $display("FAIL fsync_period: got fsync=%b after %0d cycles expected 1 after %0d",
                     fsync_a, since, TOTAL);
        end
    endtask

    task automatic test_random_en();
        int bad = 0;
        for (int i = 0; i < 3 * TOTAL; i++) begin
            step(1'b0, $urandom_range(0, 9) < 7);
            if (vec_a !== exp_vec(1'b1) || vec_b !== exp_vec(1'b0)) begin
                bad++;
                if (bad < 5)
                    $display("FAIL random_en: got %h/%h expected %h/%h",
                             vec_a, vec_b, exp_vec(1'b1), exp_vec(1'b0));
            end
        end
        tests++;
        if (bad != 0) fails++;
    endtask

    task automatic test_stall();
        int target = (3 + VBL) * HT + (5 + HBL);
        int guard = 0;
        int bad = 0;
        while (t != target && guard < 2 * TOTAL) begin
            step(1'b0, 1'b1);
            guard++;
        end
        tests++;
        if (hpos_a !== 12'sd5 || vpos_a !== 12'sd3) begin
            fails++;
            $display("FAIL stall_reach: got %0d,%0d expected 5,3", hpos_a, vpos_a);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            if (vec_a !== exp_vec(1'b1) || vec_b !== exp_vec(1'b0) || fsync_a !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold: got %h expected %h", vec_a, exp_vec(1'b1));
            end
        end
        tests++;
        if (bad != 0) fails++;
        step(1'b0, 1'b1);
        tests++;
        if (hpos_a !== 12'sd6 || vpos_a !== 12'sd3 || vec_a !== exp_vec(1'b1)) begin
            fails++;
            $display("FAIL stall_resume: got %0d,%0d expected 6,3", hpos_a, vpos_a);
        end
    endtask

    task automatic test_stall_on_fsync();
        int guard = 0;
        int cnt = 0;
        int bad = 0;
        while (!fs && guard < 2 * TOTAL) begin
            step(1'b0, 1'b1);
            guard++;
        end
        tests++;
        if (fsync_a !== 1'b1) begin
            fails++;
            $display("FAIL fsync_reach: got %b expected 1", fsync_a);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
            if (vec_a !== exp_vec(1'b1) || fsync_a !== 1'b0) begin
                bad++;
                $display("FAIL fsync_stall: got %h expected %h", vec_a, exp_vec(1'b1));
            end
        end
        step(1'b0, 1'b1);
        cnt = 1;
        if (fsync_a !== 1'b0) begin
            bad++;
            $display("FAIL fsync_repulse: got %b expected 0", fsync_a);
        end
        while (fsync_a !== 1'b1 && cnt < 2 * TOTAL) begin
            step(1'b0, 1'b1);
            cnt++;
        end
        tests++;
        if (bad != 0) fails++;
        tests++;
        if (cnt != TOTAL) begin
            fails++;
            $display("FAIL fsync_after_stall: got %0d enabled cycles expected %0d", cnt, TOTAL);
        end
    endtask

    task automatic test_reset_midframe();
        int pulses = 0;
        int n = $urandom_range(50, 300);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        tests++;
        if (vec_a !== exp_vec(1'b1) || hpos_a !== 12'(HA - 1) || frame_count_a !== 16'd0) begin
            fails++;
            $display("FAIL reset_mid: got %h expected %h", vec_a, exp_vec(1'b1));
        end
        step(1'b0, 1'b0);
        tests++;
        if (vec_a !== exp_vec(1'b1)) begin
            fails++;
            $display("FAIL reset_hold: got %h expected %h", vec_a, exp_vec(1'b1));
        end
        for (int i = 0; i < 2 * TOTAL + 1; i++) begin
            step(1'b0, 1'b1);
            pulses += fsync_a;
        end
        tests++;
        if (pulses != 3 || frame_count_a !== (FC_EN ? 16'd3 : 16'd0) || vec_a !== exp_vec(1'b1)) begin
            fails++;
            $display("FAIL frame_count: got %0d pulses count=%0d expected 3 pulses count=%0d",
                     pulses, frame_count_a, FC_EN ? 3 : 0);
        end
    endtask

    initial begin
        t = TOTAL - 1;
        fresh = 1'b1;
        fs = 1'b0;
        fc = 0;
        test_reset();
        test_first_cycle();
        test_full_frame();
        test_random_en();
        test_stall();
        test_stall_on_fsync();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
